// File: rtl/processor_controller_if.sv
// Bus between the controller and the ROM / register file / data RAM / ALU.
// The controller drives the master side; the datapath sits on the slave side.
interface processor_controller_if #(
  parameter int PC_WIDTH       = 7,
  parameter int INSTR_WIDTH    = 16,
  parameter int D_ADDR_WIDTH   = 8,
  parameter int REG_ADDR_WIDTH = 4
);
  logic [INSTR_WIDTH-1:0]    Instr;
  logic [PC_WIDTH-1:0]       PC_Addr;
  logic [D_ADDR_WIDTH-1:0]   D_Addr;
  logic                      D_Wr;
  logic                      RF_Sel;
  logic [REG_ADDR_WIDTH-1:0] RF_W_Addr;
  logic                      RF_W_En;
  logic [REG_ADDR_WIDTH-1:0] RF_Ra_Addr;
  logic [REG_ADDR_WIDTH-1:0] RF_Rb_Addr;
  logic [2:0]                ALU_Sel;
  logic                      Halted;
  logic [3:0]                State;

  modport master (
    input  Instr,
    output PC_Addr, D_Addr, D_Wr, RF_Sel, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, Halted, State
  );

  modport slave (
    output Instr,
    input  PC_Addr, D_Addr, D_Wr, RF_Sel, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, Halted, State
  );
endinterface

// File: rtl/processor_controller.sv
// Multi-cycle controller: PC, IR and a Moore FSM that fetches, decodes and
// sequences register-file / data-RAM / ALU control for each instruction.
module processor_controller #(
  parameter int PC_WIDTH       = 7,
  parameter int INSTR_WIDTH    = 16,
  parameter int D_ADDR_WIDTH   = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input logic Clk,
  input logic Reset,
  processor_controller_if.master bus
);
  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_NOOP   = 4'd3;
  localparam logic [3:0] S_LOAD_A = 4'd4;
  localparam logic [3:0] S_LOAD_B = 4'd5;
  localparam logic [3:0] S_STORE  = 4'd6;
  localparam logic [3:0] S_ADD    = 4'd7;
  localparam logic [3:0] S_SUB    = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;

  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  logic [3:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [3:0]             opcode;

  assign opcode = ir_q[INSTR_WIDTH-1 -: 4];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = bus.Instr;
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Unknown opcodes fall through to the NOOP path.
        case (opcode)
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_HALT:   state_d = S_HALT;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    bus.PC_Addr    = pc_q;
    bus.State      = state_q;
    bus.D_Addr     = '0;
    bus.D_Wr       = 1'b0;
    bus.RF_Sel     = 1'b0;
    bus.RF_W_Addr  = '0;
    bus.RF_W_En    = 1'b0;
    bus.RF_Ra_Addr = '0;
    bus.RF_Rb_Addr = '0;
    bus.ALU_Sel    = 3'b000;
    bus.Halted     = 1'b0;
    case (state_q)
      // LOAD_A only presents the address; the write lands a cycle later
      // once the synchronous RAM has its data out.
      S_LOAD_A: begin
        bus.D_Addr = ir_q[11:4];
        bus.RF_Sel = 1'b1;
      end
      S_LOAD_B: begin
        bus.D_Addr    = ir_q[11:4];
        bus.RF_Sel    = 1'b1;
        bus.RF_W_Addr = ir_q[3:0];
        bus.RF_W_En   = 1'b1;
      end
      S_STORE: begin
        bus.D_Addr     = ir_q[7:0];
        bus.RF_Ra_Addr = ir_q[11:8];
        bus.D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_Addr = ir_q[11:8];
        bus.RF_Rb_Addr = ir_q[7:4];
        bus.RF_W_Addr  = ir_q[3:0];
        bus.RF_W_En    = 1'b1;
        bus.ALU_Sel    = (state_q == S_ADD) ? 3'b001 : 3'b010;
      end
      S_HALT:  bus.Halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_processor_controller.sv
// Directed bench for processor_controller: a small ROM model feeds Instr and
// each step checks the controller outputs against hand-computed values.
module tb_processor_controller;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] rom [128];

  processor_controller_if bus ();
  processor_controller dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  assign bus.Instr = rom[bus.PC_Addr];

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_strobes(input string tag);
    chk({tag, ".wen"}, 32'(bus.RF_W_En), 32'd0);
    chk({tag, ".dwr"}, 32'(bus.D_Wr), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h3123;
    rom[1] = 16'h21B5;
    rom[2] = 16'h1A40;
    rom[3] = 16'hF000;
    rom[4] = 16'h5000;

    // Reset held two cycles
    tick(); tick();
    chk("rst.state", 32'(bus.State), 32'd0);
    chk("rst.pc", 32'(bus.PC_Addr), 32'd0);
    chk("rst.halted", 32'(bus.Halted), 32'd0);
    chk("rst.dad", 32'(bus.D_Addr), 32'd0);
    chk("rst.alu", 32'(bus.ALU_Sel), 32'd0);
    chk_idle_strobes("rst");
    Reset = 1'b0;
    tick();
    chk("init2fetch.state", 32'(bus.State), 32'd1);
    chk("init2fetch.pc", 32'(bus.PC_Addr), 32'd0);

    // ADD R3 = R1 + R2
    tick();
    chk("add.dec.state", 32'(bus.State), 32'd2);
    chk("add.dec.pc", 32'(bus.PC_Addr), 32'd1);
    chk_idle_strobes("add.dec");
    tick();
    chk("add.state", 32'(bus.State), 32'd7);
    chk("add.ra", 32'(bus.RF_Ra_Addr), 32'd1);
    chk("add.rb", 32'(bus.RF_Rb_Addr), 32'd2);
    chk("add.wa", 32'(bus.RF_W_Addr), 32'd3);
    chk("add.wen", 32'(bus.RF_W_En), 32'd1);
    chk("add.alu", 32'(bus.ALU_Sel), 32'd1);
    chk("add.sel", 32'(bus.RF_Sel), 32'd0);
    chk("add.pc", 32'(bus.PC_Addr), 32'd1);
    tick();
    chk("add.fetch.state", 32'(bus.State), 32'd1);
    chk_idle_strobes("add.fetch");

    // LOAD R5 = M[1B]
    tick();
    chk("ld.dec.state", 32'(bus.State), 32'd2);
    chk("ld.dec.pc", 32'(bus.PC_Addr), 32'd2);
    tick();
    chk("lda.state", 32'(bus.State), 32'd4);
    chk("lda.dad", 32'(bus.D_Addr), 32'h1B);
    chk("lda.sel", 32'(bus.RF_Sel), 32'd1);
    chk_idle_strobes("lda");
    tick();
    chk("ldb.state", 32'(bus.State), 32'd5);
    chk("ldb.dad", 32'(bus.D_Addr), 32'h1B);
    chk("ldb.sel", 32'(bus.RF_Sel), 32'd1);
    chk("ldb.wen", 32'(bus.RF_W_En), 32'd1);
    chk("ldb.wa", 32'(bus.RF_W_Addr), 32'd5);
    chk("ldb.alu", 32'(bus.ALU_Sel), 32'd0);
    tick();
    chk("ld.fetch.state", 32'(bus.State), 32'd1);

    // STORE M[40] = RA
    tick();
    chk("st.dec.pc", 32'(bus.PC_Addr), 32'd3);
    tick();
    chk("st.state", 32'(bus.State), 32'd6);
    chk("st.dwr", 32'(bus.D_Wr), 32'd1);
    chk("st.dad", 32'(bus.D_Addr), 32'h40);
    chk("st.ra", 32'(bus.RF_Ra_Addr), 32'hA);
    chk("st.wen", 32'(bus.RF_W_En), 32'd0);
    tick();
    chk("st.fetch.state", 32'(bus.State), 32'd1);
    chk_idle_strobes("st.fetch");

    // Illegal opcode behaves as NOOP
    tick();
    chk("ill.dec.pc", 32'(bus.PC_Addr), 32'd4);
    tick();
    chk("ill.state", 32'(bus.State), 32'd3);
    chk_idle_strobes("ill");
    tick();
    chk("ill.fetch.state", 32'(bus.State), 32'd1);

    // HALT freezes state and PC
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt.state", 32'(bus.State), 32'd9);
      chk("halt.flag", 32'(bus.Halted), 32'd1);
      chk("halt.pc", 32'(bus.PC_Addr), 32'd5);
      tick();
    end
    Reset = 1'b1;
    tick();
    chk("halt.rst.state", 32'(bus.State), 32'd0);
    chk("halt.rst.pc", 32'(bus.PC_Addr), 32'd0);
    chk("halt.rst.flag", 32'(bus.Halted), 32'd0);

    // PC wrap after 127 NOOPs, then reset during LOAD_A
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[127] = 16'h21B5;
    Reset = 1'b0;
    tick();
    for (int i = 0; i < 127 * 3; i++) begin
      chk("noop.wen", 32'(bus.RF_W_En), 32'd0);
      tick();
    end
    chk("wrap.fetch.state", 32'(bus.State), 32'd1);
    chk("wrap.fetch.pc", 32'(bus.PC_Addr), 32'd127);
    tick();
    chk("wrap.dec.state", 32'(bus.State), 32'd2);
    chk("wrap.pc", 32'(bus.PC_Addr), 32'd0);
    tick();
    chk("wrap.lda.state", 32'(bus.State), 32'd4);
    chk("wrap.lda.dad", 32'(bus.D_Addr), 32'h1B);
    Reset = 1'b1;
    tick();
    chk("lda.rst.state", 32'(bus.State), 32'd0);
    chk("lda.rst.pc", 32'(bus.PC_Addr), 32'd0);
    chk("lda.rst.wen", 32'(bus.RF_W_En), 32'd0);
    Reset = 1'b0;
    tick();
    chk("lda.rel.state", 32'(bus.State), 32'd1);
    chk("lda.rel.wen", 32'(bus.RF_W_En), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
